// File: rtl/fixed_p_seq_div.sv
// Unsigned fixed-point sequential divider: (left << FRACT_WIDTH) / right,
// one restoring shift-subtract step per clock, with a go/done handshake.
module fixed_p_seq_div #(
  parameter int WIDTH       = 32,
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             done
);

  localparam int N  = WIDTH + FRACT_WIDTH;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  generate
    if (INT_WIDTH + FRACT_WIDTH != WIDTH) begin : g_bad_params
      $error("fixed_p_seq_div: INT_WIDTH + FRACT_WIDTH must equal WIDTH");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0] out_quotient_q, out_quotient_d;
  logic [WIDTH-1:0] out_remainder_q, out_remainder_d;
  logic             overflow_q, overflow_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             done_q, done_d;

  // One iteration step; the shifted remainder carries an extra bit so the
  // compare never loses the bit shifted out of the top.
  logic [WIDTH:0]   r_shift;
  logic             r_ge;
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] r_step;
  logic [N-1:0]     quo_step;

  always_comb begin
    r_shift  = {rem_q, dvd_q[N-1]};
    r_ge     = (r_shift >= {1'b0, dvs_q});
    r_diff   = r_shift[WIDTH-1:0] - dvs_q;
    r_step   = r_ge ? r_diff : r_shift[WIDTH-1:0];
    quo_step = {quo_q[N-2:0], r_ge};
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    dvd_d           = dvd_q;
    dvs_d           = dvs_q;
    rem_d           = rem_q;
    quo_d           = quo_q;
    out_quotient_d  = out_quotient_q;
    out_remainder_d = out_remainder_q;
    overflow_d      = overflow_q;
    div_by_zero_d   = div_by_zero_q;
    done_d          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (right != '0) begin
            dvd_d         = {left, {FRACT_WIDTH{1'b0}}};
            dvs_d         = right;
            rem_d         = '0;
            quo_d         = '0;
            cnt_d         = '0;
            overflow_d    = 1'b0;
            div_by_zero_d = 1'b0;
            state_d       = S_BUSY;
          end else begin
            out_quotient_d  = '1;
            out_remainder_d = left;
            overflow_d      = 1'b1;
            div_by_zero_d   = 1'b1;
            done_d          = 1'b1;
            state_d         = S_DONE;
          end
        end
      end

      S_BUSY: begin
        dvd_d = {dvd_q[N-2:0], 1'b0};
        rem_d = r_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          out_quotient_d  = quo_step[WIDTH-1:0];
          out_remainder_d = r_step;
          // Any set bit above the result width means the quotient did not fit.
          overflow_d      = |quo_step[N-1:WIDTH];
          done_d          = 1'b1;
          state_d         = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      dvd_q           <= '0;
      dvs_q           <= '0;
      rem_q           <= '0;
      quo_q           <= '0;
      out_quotient_q  <= '0;
      out_remainder_q <= '0;
      overflow_q      <= 1'b0;
      div_by_zero_q   <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      dvd_q           <= dvd_d;
      dvs_q           <= dvs_d;
      rem_q           <= rem_d;
      quo_q           <= quo_d;
      out_quotient_q  <= out_quotient_d;
      out_remainder_q <= out_remainder_d;
      overflow_q      <= overflow_d;
      div_by_zero_q   <= div_by_zero_d;
      done_q          <= done_d;
    end
  end

  assign out_quotient  = out_quotient_q;
  assign out_remainder = out_remainder_q;
  assign overflow      = overflow_q;
  assign div_by_zero   = div_by_zero_q;
  assign done          = done_q;

endmodule

// File: tb/tb_fixed_p_seq_div.sv
// Self-checking bench for fixed_p_seq_div in an 8-bit (4.4) configuration:
// table-driven operations, scoreboard on done, plus reset and back-to-back cases.
module tb_fixed_p_seq_div;

  localparam int W = 8;
  localparam int I = 4;
  localparam int F = 4;
  localparam int N = W + F;

  logic         clk = 1'b0;
  logic         reset;
  logic         go;
  logic [W-1:0] left;
  logic [W-1:0] right;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic         overflow;
  logic         div_by_zero;
  logic         done;

  fixed_p_seq_div #(.WIDTH(W), .INT_WIDTH(I), .FRACT_WIDTH(F)) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .left          (left),
    .right         (right),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .overflow      (overflow),
    .div_by_zero   (div_by_zero),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic [W-1:0] q;
    logic [W-1:0] rem;
    logic         ovf;
    logic         dbz;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] rem;
    logic         ovf;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Scoreboard: every done pulse is matched against the oldest pending result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("done: q=%02h rem=%02h ovf=%0b dbz=%0b (exp %02h %02h %0b %0b)",
                 out_quotient, out_remainder, overflow, div_by_zero, e.q, e.rem, e.ovf, e.dbz);
        chk("quotient",    32'(out_quotient),  32'(e.q));
        chk("remainder",   32'(out_remainder), 32'(e.rem));
        chk("overflow",    32'(overflow),      32'(e.ovf));
        chk("div_by_zero", 32'(div_by_zero),   32'(e.dbz));
      end
    end
  end

  task automatic run_op(input vec_t v);
    exp_t         e;
    int           lat;
    bit           seen;
    bit           stable;
    logic [W-1:0] hq;
    logic [W-1:0] hr;
    @(posedge clk); #1;
    go = 1'b1; left = v.l; right = v.r;
    e.q = v.q; e.rem = v.rem; e.ovf = v.ovf; e.dbz = v.dbz;
    sb.push_back(e);
    hq = out_quotient; hr = out_remainder;
    @(posedge clk); #1;
    go = 1'b0;
    left  = W'($urandom);
    right = W'($urandom);
    seen = 1'b0; stable = 1'b1; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i; seen = 1'b1;
        break;
      end
      if (out_quotient !== hq || out_remainder !== hr) stable = 1'b0;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), (v.r == '0) ? 32'd1 : 32'(N + 1));
    if (v.r != '0) chk("busy_stable", 32'(stable), 32'd1);
  endtask

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int c1;
    int c2;
    bit seen;
    bit stable;

    tbl[0]  = '{8'h30, 8'h20, 8'h18, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{8'h10, 8'h30, 8'h05, 8'h10, 1'b0, 1'b0};
    tbl[2]  = '{8'hF0, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[3]  = '{8'h42, 8'h00, 8'hFF, 8'h42, 1'b1, 1'b1};
    tbl[4]  = '{8'hFF, 8'hFF, 8'h10, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{8'h01, 8'hFF, 8'h00, 8'h10, 1'b0, 1'b0};
    tbl[6]  = '{8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{8'h80, 8'h10, 8'h80, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{8'hFF, 8'h0F, 8'h10, 8'h00, 1'b1, 1'b0};
    tbl[9]  = '{8'h7F, 8'h03, 8'hA5, 8'h01, 1'b1, 1'b0};
    tbl[10] = '{8'h12, 8'h34, 8'h05, 8'h1C, 1'b0, 1'b0};
    tbl[11] = '{8'h0F, 8'hFF, 8'h00, 8'hF0, 1'b0, 1'b0};
    tbl[12] = '{8'h00, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1};

    reset = 1'b1; go = 1'b0; left = '0; right = '0;
    #1;
    chk("reset_q",    32'(out_quotient),  32'd0);
    chk("reset_rem",  32'(out_remainder), 32'd0);
    chk("reset_ovf",  32'(overflow),      32'd0);
    chk("reset_dbz",  32'(div_by_zero),   32'd0);
    chk("reset_done", 32'(done),          32'd0);
    @(negedge clk); reset = 1'b0;

    foreach (tbl[k]) run_op(tbl[k]);

    // Reset in the middle of an operation; previous result 0x18 makes the clear visible.
    run_op(tbl[0]);
    @(posedge clk); #1;
    go = 1'b1; left = 8'h30; right = 8'h20;
    sb.push_back('{8'h18, 8'h00, 1'b0, 1'b0});
    @(posedge clk); #1;
    go = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midreset_q",    32'(out_quotient),  32'd0);
    chk("midreset_rem",  32'(out_remainder), 32'd0);
    chk("midreset_ovf",  32'(overflow),      32'd0);
    chk("midreset_done", 32'(done),          32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("no_done_after_reset", 32'(seen), 32'd0);
    run_op(tbl[1]);

    // Back-to-back with go held high; operand changes after accept must be ignored.
    @(posedge clk); #1;
    go = 1'b1; left = 8'h30; right = 8'h20;
    sb.push_back('{8'h18, 8'h00, 1'b0, 1'b0});
    sb.push_back('{8'h20, 8'h00, 1'b0, 1'b0});
    @(posedge clk); #1;
    left = 8'h40;
    seen = 1'b0; c1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1; c1 = cyc;
        break;
      end
    end
    chk("b2b_done1", 32'(seen), 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    go = 1'b0;
    seen = 1'b0; stable = 1'b1; c2 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1; c2 = cyc;
        break;
      end
      if (out_quotient !== 8'h18 || out_remainder !== 8'h00) stable = 1'b0;
    end
    chk("b2b_done2",  32'(seen),    32'd1);
    chk("b2b_spacing", 32'(c2 - c1), 32'd14);
    chk("b2b_stable", 32'(stable),  32'd1);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_p_seq_div.md
Name: fixed_p_seq_div

Overview:
- Multi-cycle, synthesizable unsigned fixed-point divider built on a restoring shift-subtract FSM.
- Computes (left << FRACT_WIDTH) / right one quotient bit per cycle, using a go/done handshake.
- Replaces the single-cycle behavioural divide in synthesis flows; the compiler schedules it like any other multi-cycle primitive.

Parameters:
- WIDTH, 32, total operand and result width in bits.
- INT_WIDTH, 8, integer bits of operands and quotient.
- FRACT_WIDTH, 24, fractional bits. Must satisfy INT_WIDTH + FRACT_WIDTH == WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- go  input  1  start request; sampled only in IDLE.
- left  input  WIDTH  dividend, unsigned fixed point.
- right  input  WIDTH  divisor, unsigned fixed point.
- out_quotient  output  WIDTH  quotient, truncated toward zero.
- out_remainder  output  WIDTH  remainder of the extended dividend.
- overflow  output  1  true quotient >= 2^WIDTH, or divide by zero.
- div_by_zero  output  1  right was 0 at accept.
- done  output  1  one-cycle result-valid pulse.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, reset).
- Reset (asserted at any time, including mid-operation):
  - state = IDLE; iteration counter = 0; all internal registers = 0.
  - out_quotient, out_remainder, overflow, div_by_zero, done all = 0.
- States: IDLE, BUSY, DONE. Let N = WIDTH + FRACT_WIDTH.
- IDLE, go=1, right!=0 at an edge:
  - Latch dividend D = {left, FRACT_WIDTH zeros} (N bits), divisor = right, partial remainder = 0, counter = 0.
  - Clear overflow and div_by_zero. Next state BUSY.
- IDLE, go=1, right==0: next state DONE.
  - Register quotient = all ones, remainder = left, overflow = 1, div_by_zero = 1.
  - done is visible in the following cycle (latency 1).
- IDLE, go=0: hold all outputs. The last result stays valid until the next accept.
- BUSY, each edge (one iteration):
  - R' = {R[WIDTH-1:0], D msb}; D shifts left by 1.
  - If R' >= divisor: R = R' - divisor and shift in quotient bit 1; else R = R' and shift in 0.
  - R is WIDTH+1 bits internally, so no carry is lost.
  - Counter increments. After the N-th iteration, next state DONE.
- Outputs on the transition to DONE:
  - out_quotient = low WIDTH bits of the N-bit quotient.
  - overflow = OR of the upper FRACT_WIDTH quotient bits.
  - out_remainder = R[WIDTH-1:0].
- DONE: done = 1 for exactly this one cycle, then unconditional return to IDLE. go is ignored in DONE.
- If go is still high in the IDLE cycle after DONE, a new operation starts (back-to-back allowed).
- Latency (right != 0): go sampled at the end of cycle c0; done high in cycle c(N+1). Defaults give 57 cycles.
- go dropping during BUSY does not abort. left/right changes after accept have no effect.
- Outputs change only at the transition to DONE or at reset. They never glitch during BUSY.

Test Plan:
- WIDTH=8, INT_WIDTH=4, FRACT_WIDTH=4, left=0x30 (3.0), right=0x20 (2.0), go pulse -> done in cycle 13; out_quotient=0x18 (1.5), out_remainder=0, overflow=0.
- Same config, left=0x10 (1.0), right=0x30 (3.0) -> out_quotient=0x05 (0.3125, truncated), out_remainder=0x10, overflow=0.
- Same config, left=0xF0 (15.0), right=0x01 (0.0625) -> quotient 240.0 exceeds range; overflow=1, out_quotient=0x00 (low bits of 0xF00).
- right=0, left=0x42, go -> done one cycle after accept; out_quotient=0xFF, out_remainder=0x42, overflow=1, div_by_zero=1.
- Assert reset in cycle 6 of an operation -> all outputs 0 immediately (asynchronous); no done pulse. A following go completes normally with correct values.
- Hold go high continuously across two operations (0x30/0x20, then 0x40/0x20) -> two done pulses 14 cycles apart; results 0x18 then 0x20. Outputs stay stable between pulses.
